// File: rtl/mem_line_fill.sv
// Line-fill engine: walks a missing line critical-word-first into main memory,
// forwards the critical word early and hands the assembled line to the controller.
module mem_line_fill #(
  parameter int ADDR_SIZE      = 15,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        miss_valid,
  input  logic [ADDR_SIZE-1:0]        miss_addr,
  output logic                        miss_ready,
  output logic [ADDR_SIZE-1:0]        mem_addr,
  input  logic [31:0]                 mem_rdata,
  output logic                        crit_valid,
  output logic [31:0]                 crit_data,
  output logic                        fill_valid,
  input  logic                        fill_ready,
  output logic [32*WORDS_PER_LINE-1:0] fill_line,
  output logic [ADDR_SIZE-1:0]        fill_addr,
  output logic                        busy
);

  localparam int W   = WORDS_PER_LINE;
  localparam int OFF = $clog2(W);
  localparam logic [OFF-1:0] LAST = OFF'(W - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   base_q, base_d;
  logic [ADDR_SIZE-1:0]   mem_addr_q, mem_addr_d;
  logic [ADDR_SIZE-1:0]   fill_addr_q, fill_addr_d;
  logic [OFF-1:0]         off_q, off_d;
  logic [OFF-1:0]         cnt_q, cnt_d;
  logic [OFF-1:0]         slot;
  logic                   iss_v_q, iss_v_d;
  logic                   iss_first_q, iss_first_d;
  logic                   iss_last_q, iss_last_d;
  logic                   rd_v_q, rd_v_d;
  logic                   rd_first_q, rd_first_d;
  logic                   rd_last_q, rd_last_d;
  logic [OFF-1:0]         rd_slot_q, rd_slot_d;
  logic                   crit_valid_q, crit_valid_d;
  logic [31:0]            crit_data_q, crit_data_d;
  logic                   fill_valid_q, fill_valid_d;
  logic [32*W-1:0]        fill_line_q, fill_line_d;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    fill_addr_d  = fill_addr_q;
    fill_valid_d = fill_valid_q;
    fill_line_d  = fill_line_q;
    crit_data_d  = crit_data_q;
    crit_valid_d = 1'b0;
    iss_v_d      = 1'b0;
    iss_first_d  = 1'b0;
    iss_last_d   = 1'b0;
    slot         = off_q + cnt_q;
    // The word sampled by memory this cycle returns next cycle.
    rd_v_d       = iss_v_q;
    rd_first_d   = iss_first_q;
    rd_last_d    = iss_last_q;
    rd_slot_d    = mem_addr_q[OFF-1:0];

    if (rd_v_q) begin
      fill_line_d[32*int'(rd_slot_q) +: 32] = mem_rdata;
      if (rd_first_q) begin
        crit_valid_d = 1'b1;
        crit_data_d  = mem_rdata;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (miss_valid) begin
          base_d      = {miss_addr[ADDR_SIZE-1:OFF], {OFF{1'b0}}};
          off_d       = miss_addr[OFF-1:0];
          mem_addr_d  = miss_addr;
          cnt_d       = OFF'(1);
          iss_v_d     = 1'b1;
          iss_first_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // Offset wraps inside the line; base bits never carry.
        mem_addr_d = {base_q[ADDR_SIZE-1:OFF], slot};
        iss_v_d    = 1'b1;
        iss_last_d = (cnt_q == LAST);
        if (cnt_q == LAST) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + OFF'(1);
        end
      end
      DRAIN: begin
        if (rd_v_q && rd_last_q) begin
          fill_valid_d = 1'b1;
          fill_addr_d  = base_q;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (fill_ready) begin
          fill_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      base_q       <= '0;
      off_q        <= '0;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      fill_addr_q  <= '0;
      fill_valid_q <= 1'b0;
      fill_line_q  <= '0;
      crit_data_q  <= '0;
      crit_valid_q <= 1'b0;
      iss_v_q      <= 1'b0;
      iss_first_q  <= 1'b0;
      iss_last_q   <= 1'b0;
      rd_v_q       <= 1'b0;
      rd_first_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_slot_q    <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      fill_addr_q  <= fill_addr_d;
      fill_valid_q <= fill_valid_d;
      fill_line_q  <= fill_line_d;
      crit_data_q  <= crit_data_d;
      crit_valid_q <= crit_valid_d;
      iss_v_q      <= iss_v_d;
      iss_first_q  <= iss_first_d;
      iss_last_q   <= iss_last_d;
      rd_v_q       <= rd_v_d;
      rd_first_q   <= rd_first_d;
      rd_last_q    <= rd_last_d;
      rd_slot_q    <= rd_slot_d;
    end
  end

  assign miss_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign mem_addr   = mem_addr_q;
  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;
  assign fill_valid = fill_valid_q;
  assign fill_line  = fill_line_q;
  assign fill_addr  = fill_addr_q;

endmodule

// File: tb/tb_mem_line_fill.sv
// Bench for mem_line_fill: memory returns data = address; lines checked
// against arithmetic expectations for directed and random misses.
module tb_mem_line_fill;

  localparam int AW = 15;
  localparam int W  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            miss_valid;
  logic [AW-1:0]   miss_addr;
  logic            miss_ready;
  logic [AW-1:0]   mem_addr;
  logic [31:0]     mem_rdata = '0;
  logic            crit_valid;
  logic [31:0]     crit_data;
  logic            fill_valid;
  logic            fill_ready;
  logic [32*W-1:0] fill_line;
  logic [AW-1:0]   fill_addr;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_t0 = -100;

  mem_line_fill #(.ADDR_SIZE(AW), .WORDS_PER_LINE(W)) dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_addr(miss_addr),
    .miss_ready(miss_ready), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .crit_valid(crit_valid),
    .crit_data(crit_data), .fill_valid(fill_valid),
    .fill_ready(fill_ready), .fill_line(fill_line),
    .fill_addr(fill_addr), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_rdata <= 32'(mem_addr);

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_line(input int a);
    logic [127:0] l;
    int base;
    base = a & ('h7fff & ~(W - 1));
    l = '0;
    for (int i = 0; i < W; i++) l[32*i +: 32] = 32'(base + i);
    return l;
  endfunction

  task automatic run_miss(input int a, input bit bp, input bit hold,
                          input int nxt, input bit chk_gap);
    int base;
    int off;
    int n;
    int k;
    bit acc;
    logic [127:0] line;
    base = a & ('h7fff & ~(W - 1));
    off  = a % W;
    line = exp_line(a);
    fill_ready = !bp;
    miss_addr  = AW'(a);
    miss_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      if (busy) acc = 1'b1;
      else n++;
    end
    check("accept", 128'(acc), 128'(1));
    if (!acc) begin
      miss_valid = 1'b0;
      return;
    end
    check("acc_lat", 128'(n), 128'(0));
    if (chk_gap) check("gap", 128'(cyc - last_t0), 128'(W + 3));
    last_t0 = cyc;
    if (!hold) miss_valid = 1'b0;
    check("addr0", 128'(mem_addr), 128'(base + off));
    check("mready_busy", 128'(miss_ready), 128'(0));
    for (int c = 1; c <= W + 1; c++) begin
      @(negedge clk);
      k = (c < W) ? c : W - 1;
      check("addr", 128'(mem_addr), 128'(base + ((off + k) % W)));
      check("crit_v", 128'(crit_valid), 128'(c == 2));
      if (c == 2) check("crit_d", 128'(crit_data), 128'(a));
      check("fill_v", 128'(fill_valid), 128'(c == W + 1));
    end
    check("line", fill_line, line);
    check("faddr", 128'(fill_addr), 128'(base));
    if (bp) begin
      miss_valid = 1'b1;
      miss_addr  = AW'(nxt);
      repeat (3) begin
        @(negedge clk);
        check("bp_v", 128'(fill_valid), 128'(1));
        check("bp_line", fill_line, line);
        check("bp_faddr", 128'(fill_addr), 128'(base));
        check("bp_mready", 128'(miss_ready), 128'(0));
      end
      fill_ready = 1'b1;
    end
    @(negedge clk);
    check("hs_v", 128'(fill_valid), 128'(0));
    check("hs_mready", 128'(miss_ready), 128'(1));
    check("hs_busy", 128'(busy), 128'(0));
  endtask

  initial begin
    int a;
    int nx;
    bit bp;
    reset      = 1'b1;
    miss_valid = 1'b1;
    miss_addr  = AW'('h55);
    fill_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_maddr", 128'(mem_addr), 128'(0));
    check("rst_faddr", 128'(fill_addr), 128'(0));
    check("rst_line", fill_line, 128'(0));
    check("rst_cdata", 128'(crit_data), 128'(0));
    check("rst_fv", 128'(fill_valid), 128'(0));
    check("rst_cv", 128'(crit_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_mready", 128'(miss_ready), 128'(1));
    reset      = 1'b0;
    miss_valid = 1'b0;
    @(negedge clk);
    check("idle_busy", 128'(busy), 128'(0));

    run_miss('h0010, 0, 0, 0, 0);
    run_miss('h0012, 0, 0, 0, 0);
    run_miss('h7fff, 0, 0, 0, 0);
    run_miss('h0005, 1, 0, 'h0033, 0);
    run_miss('h0033, 0, 0, 0, 0);

    fill_ready = 1'b1;
    miss_addr  = AW'('h20);
    miss_valid = 1'b1;
    @(negedge clk);
    check("rm_busy", 128'(busy), 128'(1));
    miss_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rm_maddr", 128'(mem_addr), 128'(0));
    check("rm_faddr", 128'(fill_addr), 128'(0));
    check("rm_line", fill_line, 128'(0));
    check("rm_cdata", 128'(crit_data), 128'(0));
    check("rm_cv", 128'(crit_valid), 128'(0));
    check("rm_fv", 128'(fill_valid), 128'(0));
    check("rm_busy0", 128'(busy), 128'(0));
    check("rm_mready", 128'(miss_ready), 128'(1));
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("rm_quiet_cv", 128'(crit_valid), 128'(0));
      check("rm_quiet_fv", 128'(fill_valid), 128'(0));
      check("rm_quiet_mr", 128'(miss_ready), 128'(1));
    end
    run_miss('h0040, 0, 0, 0, 0);

    run_miss('h0100, 0, 1, 0, 0);
    run_miss('h0205, 0, 1, 0, 1);
    run_miss('h03ff, 0, 1, 0, 1);
    run_miss('h7ffd, 0, 1, 0, 1);

    a = $urandom_range(0, 'h7fff);
    for (int i = 0; i < 20; i++) begin
      nx = $urandom_range(0, 'h7fff);
      bp = 1'($urandom_range(0, 1));
      run_miss(a, bp, 0, nx, 0);
      a = nx;
    end
    miss_valid = 1'b0;
    @(negedge clk);
    check("end_busy", 128'(busy), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_line_fill.md
# mem_line_fill

Line-fill engine between the cache controller and the main-memory model. On a miss it walks the missing line's word addresses into the memory's address port, critical word first, one per cycle. It captures each returned word one cycle after that word's address is sampled and assembles a full line. The critical word is forwarded early; the completed line is held under a valid/ready handshake until the controller takes it.

## Interface
- ADDR_SIZE, 15, word-address width; matches the main-memory address port
- WORDS_PER_LINE, 4, words per cache line; power of two, 2..16
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; priority over all other inputs
- miss_valid  in  1  controller presents a miss
- miss_addr  in  ADDR_SIZE  word address that missed
- miss_ready  out  1  engine can accept a miss; combinational, high exactly when state is IDLE
- mem_addr  out  ADDR_SIZE  registered address driven to the main-memory address port
- mem_rdata  in  32  main-memory read data; valid one clock after mem_addr is sampled
- crit_valid  out  1  one-cycle pulse: requested word available
- crit_data  out  32  requested word, valid with crit_valid
- fill_valid  out  1  assembled line available
- fill_ready  in  1  controller accepts line
- fill_line  out  32*WORDS_PER_LINE  line data; word i at bits [32i+31:32i]
- fill_addr  out  ADDR_SIZE  line base address (offset bits zero)
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, DRAIN, DONE. OFF = log2(WORDS_PER_LINE); W = WORDS_PER_LINE.
- IDLE: on miss_valid && miss_ready:
  - latch base = miss_addr with low OFF bits cleared, and off = miss_addr[OFF-1:0]
  - mem_addr <= base | off; issue count <= 1; go ISSUE
- ISSUE: each cycle, mem_addr <= base | ((off+k) mod W) for the next k.
  - After word W-1 has been driven, go DRAIN.
  - Offset arithmetic wraps modulo W inside the line. Base bits are never incremented, so there is no carry into base (line at 0x7FFC..0x7FFF stays in range).
- Capture: a 1-bit valid pipeline, delayed one cycle from each issue, tracks returning words.
  - Word k is written into slot (off+k) mod W of fill_line.
  - k=0 also drives crit_data and pulses crit_valid for exactly one cycle.
- DRAIN: wait for the last capture, then set fill_valid and fill_addr=base; go DONE.
- DONE: hold fill_valid, fill_line and fill_addr stable until fill_valid && fill_ready. On that edge clear fill_valid and go IDLE. miss_ready rises the following cycle, so no miss is accepted in the handshake cycle.
- fill_line keeps its stale contents in IDLE. It is meaningful only while fill_valid is high.
- mem_addr holds its last value when not issuing.
- Reset (any state, including mid-fill):
  - state IDLE; mem_addr, fill_line, fill_addr, crit_data = 0; fill_valid, crit_valid, busy = 0
  - valid pipeline cleared, so in-flight memory data is discarded
  - miss_valid is ignored in the reset cycle

## Timing
- Acceptance at edge E0: word k address visible after E(k). Memory samples it at E(k+1); the engine captures it at E(k+2).
- crit_valid high during the cycle after E2.
- Last capture at E(W+1); fill_valid high after E(W+1). W=4 gives fill_valid 5 cycles after acceptance.
- Minimum miss-to-miss spacing: W+3 cycles, when fill_ready is already high as fill_valid rises.
- fill_ready high before fill_valid is legal; the handshake completes on the first edge where both are high.

## Test plan
Memory model returns data = address; W=4 throughout.
- **Aligned miss:** miss_addr 0x0010 → mem_addr sequence 0x10,0x11,0x12,0x13. crit_data 0x10 after E2. fill_valid after E5 with fill_line {0x13,0x12,0x11,0x10} (MSW..LSW) and fill_addr 0x0010.
- **Critical word first:** miss_addr 0x0012 → mem_addr 0x12,0x13,0x10,0x11. crit_data 0x12. fill_line in natural order {0x13,0x12,0x11,0x10}.
- **Top of memory:** miss_addr 0x7FFF → mem_addr 0x7FFF,0x7FFC,0x7FFD,0x7FFE. fill_addr 0x7FFC; no address outside 0x7FFC..0x7FFF.
- **Backpressure:** fill_ready low for 3 cycles after fill_valid → fill_line and fill_addr stable, miss_ready low, and a pending miss_valid is not accepted. Line is taken on the first fill_ready edge; the new miss is accepted one cycle later.
- **Reset mid-fill:** reset asserted at E3 of a fill to 0x0020 → all outputs 0, miss_ready high after release, no crit_valid or fill_valid from the aborted fill. Next miss 0x0040 completes with correct data.
- **Back-to-back:** miss_valid held high with fill_ready tied high → successive misses accepted exactly W+3 cycles apart, each line correct.
